// File: rtl/immediate_encoder_pkg.sv
// -----------------------------------------------------------------------------
// immediate_encoder_pkg
// Shared definitions for the Format I immediate encoder:
//   - register numbers used as constant-generator sources (R0, R2/CG1, R3/CG2)
//   - As addressing-mode codes
//   - out_kind word-type codes
//   - encoder FSM state type
//   - helper that packs the Format I instruction word
// -----------------------------------------------------------------------------
package immediate_encoder_pkg;

  // Register numbers
  localparam logic [3:0] REG_R0  = 4'd0;
  localparam logic [3:0] REG_CG1 = 4'd2;  // R2 acting as constant generator 1
  localparam logic [3:0] REG_CG2 = 4'd3;  // R3 acting as constant generator 2

  // As source addressing-mode codes
  localparam logic [1:0] AS_00 = 2'b00;
  localparam logic [1:0] AS_01 = 2'b01;
  localparam logic [1:0] AS_10 = 2'b10;
  localparam logic [1:0] AS_11 = 2'b11;  // @Rn+ ; with R0 this is #imm

  // out_kind codes
  localparam logic [1:0] KIND_INSTR = 2'd0;
  localparam logic [1:0] KIND_SRCX  = 2'd1;
  localparam logic [1:0] KIND_DSTX  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_INSTR = 2'd1,
    ST_SRCX  = 2'd2,
    ST_DSTX  = 2'd3
  } state_t;

  // Format I word: {opcode, src, Ad, bw, As, dst}
  function automatic logic [15:0] pack_instr(
    input logic [3:0] opcode,
    input logic [3:0] src,
    input logic       ad,
    input logic       bw,
    input logic [1:0] as_mode,
    input logic [3:0] dst
  );
    return {opcode, src, ad, bw, as_mode, dst};
  endfunction

endpackage

// File: rtl/immediate_encoder_cg_match.sv
// -----------------------------------------------------------------------------
// imm_cg_match
// Combinational constant-generator matcher. Decides whether an immediate can
// be produced by R2/R3 constant-generator addressing instead of an extension
// word. In byte mode only imm[7:0] is compared, so byte 0xFF matches -1.
// Ports:
//   i_imm  [15:0] source immediate
//   i_bw          1 = byte operation
//   o_hit         immediate is available from a constant generator
//   o_src  [3:0]  generator register (R2 or R3); R0 when no hit
//   o_as   [1:0]  As mode selecting the constant; 11 when no hit
// -----------------------------------------------------------------------------
module imm_cg_match
  import immediate_encoder_pkg::*;
(
  input  logic [15:0] i_imm,
  input  logic        i_bw,
  output logic        o_hit,
  output logic [3:0]  o_src,
  output logic [1:0]  o_as
);

  logic [15:0] w_val;
  logic        w_is_m1;

  // Byte mode compares the low byte only; -1 is recognised separately so
  // that both 0xFF (byte) and 0xFFFF (word) hit.
  assign w_val   = i_bw ? {8'h00, i_imm[7:0]} : i_imm;
  assign w_is_m1 = i_bw ? (i_imm[7:0] == 8'hFF) : (i_imm == 16'hFFFF);

  always_comb begin
    o_hit = 1'b1;
    o_src = REG_R0;
    o_as  = AS_11;
    if (w_is_m1) begin
      o_src = REG_CG2;
      o_as  = AS_11;
    end else begin
      case (w_val)
        16'h0000: begin o_src = REG_CG2; o_as = AS_00; end
        16'h0001: begin o_src = REG_CG2; o_as = AS_01; end
        16'h0002: begin o_src = REG_CG2; o_as = AS_10; end
        16'h0004: begin o_src = REG_CG1; o_as = AS_10; end
        16'h0008: begin o_src = REG_CG1; o_as = AS_11; end
        default: begin
          o_hit = 1'b0;
          o_src = REG_R0;
          o_as  = AS_11;
        end
      endcase
    end
  end

endmodule

// File: rtl/immediate_encoder.sv
// -----------------------------------------------------------------------------
// immediate_encoder
// Encodes a Format I "op #imm, dst" request into a stream of 16-bit words:
// the instruction word, an optional source-extension word (when the immediate
// is not available from a constant generator) and an optional
// destination-extension word (indexed destination).
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. The producer holds valid and its payload until that edge; ready may
// change freely. Input side: in_valid/in_ready (in_ready high only in IDLE).
// Output side: out_valid/out_ready; out_data/out_kind/out_last are registered
// and remain stable while out_valid=1 and out_ready=0.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid, in_ready  request handshake
//   opcode, bw, imm, dstA, Ad, dst_off  request fields (latched on accept)
//   out_valid, out_ready, out_data, out_kind, out_last  word stream
//   cg_hit              one-cycle pulse after an accept that used a generator
//   words_saved         saturating count of extension words avoided
//   dbg_state           current FSM state
// -----------------------------------------------------------------------------
module immediate_encoder
  import immediate_encoder_pkg::*;
#(
  parameter int unsigned CG_ENABLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  opcode,
  input  logic        bw,
  input  logic [15:0] imm,
  input  logic [3:0]  dstA,
  input  logic        Ad,
  input  logic [15:0] dst_off,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic [1:0]  out_kind,
  output logic        out_last,
  output logic        cg_hit,
  output logic [15:0] words_saved,
  output state_t      dbg_state
);

  state_t      r_state;
  state_t      w_nxt_state;

  logic        r_out_valid;
  logic [15:0] r_out_data;
  logic [1:0]  r_out_kind;
  logic        r_out_last;
  logic        r_cg_hit;
  logic [15:0] r_words_saved;

  // Request context kept for the extension words
  logic        r_need_src;
  logic        r_ad;
  logic [15:0] r_src_word;
  logic [15:0] r_dst_off;

  logic        w_nxt_valid;
  logic [15:0] w_nxt_data;
  logic [1:0]  w_nxt_kind;
  logic        w_nxt_last;

  logic        w_accept;
  logic        w_fire;
  logic        w_hit;
  logic [3:0]  w_cg_src;
  logic [1:0]  w_cg_as;
  logic        w_cg_use;
  logic [3:0]  w_src;
  logic [1:0]  w_as;
  logic [15:0] w_src_word;

  imm_cg_match u_cg_match (
    .i_imm (imm),
    .i_bw  (bw),
    .o_hit (w_hit),
    .o_src (w_cg_src),
    .o_as  (w_cg_as)
  );

  assign w_cg_use   = (CG_ENABLE != 0) && w_hit;
  assign w_src      = w_cg_use ? w_cg_src : REG_R0;
  assign w_as       = w_cg_use ? w_cg_as  : AS_11;
  // Byte operations carry only the low byte in the extension word.
  assign w_src_word = bw ? {8'h00, imm[7:0]} : imm;

  assign in_ready    = (r_state == ST_IDLE);
  assign w_accept    = in_valid && in_ready;
  assign w_fire      = r_out_valid && out_ready;

  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_kind    = r_out_kind;
  assign out_last    = r_out_last;
  assign cg_hit      = r_cg_hit;
  assign words_saved = r_words_saved;
  assign dbg_state   = r_state;

  // Next state and next output word. Each state loads the word that the
  // following state presents, so outputs are registered on the transition.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_valid = r_out_valid;
    w_nxt_data  = r_out_data;
    w_nxt_kind  = r_out_kind;
    w_nxt_last  = r_out_last;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_nxt_state = ST_INSTR;
          w_nxt_valid = 1'b1;
          w_nxt_data  = pack_instr(opcode, w_src, Ad, bw, w_as, dstA);
          w_nxt_kind  = KIND_INSTR;
          w_nxt_last  = w_cg_use && !Ad;
        end
      end
      ST_INSTR: begin
        if (w_fire) begin
          if (r_need_src) begin
            w_nxt_state = ST_SRCX;
            w_nxt_data  = r_src_word;
            w_nxt_kind  = KIND_SRCX;
            w_nxt_last  = !r_ad;
          end else if (r_ad) begin
            w_nxt_state = ST_DSTX;
            w_nxt_data  = r_dst_off;
            w_nxt_kind  = KIND_DSTX;
            w_nxt_last  = 1'b1;
          end else begin
            w_nxt_state = ST_IDLE;
            w_nxt_valid = 1'b0;
          end
        end
      end
      ST_SRCX: begin
        if (w_fire) begin
          if (r_ad) begin
            w_nxt_state = ST_DSTX;
            w_nxt_data  = r_dst_off;
            w_nxt_kind  = KIND_DSTX;
            w_nxt_last  = 1'b1;
          end else begin
            w_nxt_state = ST_IDLE;
            w_nxt_valid = 1'b0;
          end
        end
      end
      ST_DSTX: begin
        if (w_fire) begin
          w_nxt_state = ST_IDLE;
          w_nxt_valid = 1'b0;
        end
      end
      default: begin
        w_nxt_state = ST_IDLE;
        w_nxt_valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_out_valid   <= 1'b0;
      r_out_data    <= 16'h0000;
      r_out_kind    <= KIND_INSTR;
      r_out_last    <= 1'b0;
      r_cg_hit      <= 1'b0;
      r_words_saved <= 16'h0000;
      r_need_src    <= 1'b0;
      r_ad          <= 1'b0;
      r_src_word    <= 16'h0000;
      r_dst_off     <= 16'h0000;
    end else begin
      r_state     <= w_nxt_state;
      r_out_valid <= w_nxt_valid;
      r_out_data  <= w_nxt_data;
      r_out_kind  <= w_nxt_kind;
      r_out_last  <= w_nxt_last;
      r_cg_hit    <= w_accept && w_cg_use;
      if (w_accept) begin
        r_need_src <= !w_cg_use;
        r_ad       <= Ad;
        r_src_word <= w_src_word;
        r_dst_off  <= dst_off;
        if (w_cg_use && (r_words_saved != 16'hFFFF)) begin
          r_words_saved <= r_words_saved + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_immediate_encoder.sv
module tb_immediate_encoder;
  import immediate_encoder_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  opcode;
  logic        bw;
  logic [15:0] imm;
  logic [3:0]  dstA;
  logic        Ad;
  logic [15:0] dst_off;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [1:0]  out_kind;
  logic        out_last;
  logic        cg_hit;
  logic [15:0] words_saved;
  state_t      dbg_state;

  // Second instance with constant generators disabled; shares request fields.
  logic        n_in_valid;
  logic        n_in_ready;
  logic        n_out_valid;
  logic        n_out_ready;
  logic [15:0] n_out_data;
  logic [1:0]  n_out_kind;
  logic        n_out_last;
  logic        n_cg_hit;
  logic [15:0] n_words_saved;
  state_t      n_dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  immediate_encoder #(.CG_ENABLE(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .bw(bw), .imm(imm), .dstA(dstA), .Ad(Ad), .dst_off(dst_off),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_kind(out_kind), .out_last(out_last), .cg_hit(cg_hit),
    .words_saved(words_saved), .dbg_state(dbg_state)
  );

  immediate_encoder #(.CG_ENABLE(0)) dut_nocg (
    .clk(clk), .rst(rst), .in_valid(n_in_valid), .in_ready(n_in_ready),
    .opcode(opcode), .bw(bw), .imm(imm), .dstA(dstA), .Ad(Ad), .dst_off(dst_off),
    .out_valid(n_out_valid), .out_ready(n_out_ready), .out_data(n_out_data),
    .out_kind(n_out_kind), .out_last(n_out_last), .cg_hit(n_cg_hit),
    .words_saved(n_words_saved), .dbg_state(n_dbg_state)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Driver: present one request for one cycle starting at a falling edge.
  task automatic send(input logic [3:0] op, input logic b, input logic [15:0] im,
                      input logic [3:0] d, input logic a, input logic [15:0] off);
    opcode   = op;
    bw       = b;
    imm      = im;
    dstA     = d;
    Ad       = a;
    dst_off  = off;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Check the presented word, then complete its handshake.
  task automatic expect_word(input string tag, input logic [15:0] data,
                             input logic [1:0] kind, input logic last);
    check({tag, ".valid"}, {15'd0, out_valid}, 16'h0001);
    check({tag, ".data"},  out_data, data);
    check({tag, ".kind"},  {14'd0, out_kind}, {14'd0, kind});
    check({tag, ".last"},  {15'd0, out_last}, {15'd0, last});
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic expect_idle(input string tag);
    check({tag, ".in_ready"},  {15'd0, in_ready}, 16'h0001);
    check({tag, ".out_valid"}, {15'd0, out_valid}, 16'h0000);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    n_in_valid = 1'b0; n_out_ready = 1'b0;
    opcode = 4'h0; bw = 1'b0; imm = 16'h0000; dstA = 4'h0; Ad = 1'b0; dst_off = 16'h0000;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst.in_ready",    {15'd0, in_ready}, 16'h0001);
    check("rst.out_valid",   {15'd0, out_valid}, 16'h0000);
    check("rst.out_data",    out_data, 16'h0000);
    check("rst.out_kind",    {14'd0, out_kind}, 16'h0000);
    check("rst.out_last",    {15'd0, out_last}, 16'h0000);
    check("rst.cg_hit",      {15'd0, cg_hit}, 16'h0000);
    check("rst.words_saved", words_saved, 16'h0000);
    check("rst.state",       {14'd0, dbg_state}, {14'd0, ST_IDLE});

    // #1 -> R3 As=01, single word
    send(4'h4, 1'b0, 16'h0001, 4'h5, 1'b0, 16'h0000);
    check("one.cg_hit", {15'd0, cg_hit}, 16'h0001);
    expect_word("one", 16'h4315, KIND_INSTR, 1'b1);
    check("one.cg_hit_pulse", {15'd0, cg_hit}, 16'h0000);
    check("one.words_saved", words_saved, 16'h0001);
    expect_idle("one.idle");

    // #8 -> R2 As=11
    send(4'h4, 1'b0, 16'h0008, 4'h5, 1'b0, 16'h0000);
    expect_word("eight", 16'h4235, KIND_INSTR, 1'b1);
    check("eight.words_saved", words_saved, 16'h0002);

    // #1234 -> R0 As=11 + source extension, with backpressure on the instruction
    send(4'h5, 1'b0, 16'h1234, 4'h5, 1'b0, 16'h0000);
    check("ext.cg_hit", {15'd0, cg_hit}, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; opcode = 4'hF; imm = 16'h0000;
      @(negedge clk);
      check("bp.data",     out_data, 16'h5035);
      check("bp.kind",     {14'd0, out_kind}, {14'd0, KIND_INSTR});
      check("bp.last",     {15'd0, out_last}, 16'h0000);
      check("bp.in_ready", {15'd0, in_ready}, 16'h0000);
      check("bp.state",    {14'd0, dbg_state}, {14'd0, ST_INSTR});
    end
    in_valid = 1'b0;
    expect_word("ext.instr", 16'h5035, KIND_INSTR, 1'b0);
    expect_word("ext.src",   16'h1234, KIND_SRCX,  1'b1);
    expect_idle("ext.idle");
    check("ext.words_saved", words_saved, 16'h0002);

    // Byte 0xFF -> -1 via R3 As=11
    send(4'h4, 1'b1, 16'h00FF, 4'h5, 1'b0, 16'h0000);
    expect_word("bm1", 16'h4375, KIND_INSTR, 1'b1);
    check("bm1.words_saved", words_saved, 16'h0003);

    // #4 with indexed destination -> R2 As=10, then dst_off
    send(4'h4, 1'b0, 16'h0004, 4'h5, 1'b1, 16'h0002);
    expect_word("four.instr", 16'h42A5, KIND_INSTR, 1'b0);
    expect_word("four.dst",   16'h0002, KIND_DSTX,  1'b1);
    check("four.words_saved", words_saved, 16'h0004);

    // Word 0x00FF is not -1: extension word required
    send(4'h4, 1'b0, 16'h00FF, 4'h5, 1'b0, 16'h0000);
    expect_word("wff.instr", 16'h4035, KIND_INSTR, 1'b0);
    expect_word("wff.src",   16'h00FF, KIND_SRCX,  1'b1);

    // Word 0xFFFF is -1
    send(4'h4, 1'b0, 16'hFFFF, 4'h5, 1'b0, 16'h0000);
    expect_word("wm1", 16'h4335, KIND_INSTR, 1'b1);
    check("wm1.words_saved", words_saved, 16'h0005);

    // Byte miss: high byte zeroed in the extension word
    send(4'h6, 1'b1, 16'h12FE, 4'h7, 1'b0, 16'h0000);
    expect_word("bx.instr", 16'h6077, KIND_INSTR, 1'b0);
    expect_word("bx.src",   16'h00FE, KIND_SRCX,  1'b1);

    // Source and destination extension words
    send(4'h1, 1'b0, 16'h0005, 4'h9, 1'b1, 16'hBEEF);
    expect_word("sd.instr", 16'h10B9, KIND_INSTR, 1'b0);
    expect_word("sd.src",   16'h0005, KIND_SRCX,  1'b0);
    expect_word("sd.dst",   16'hBEEF, KIND_DSTX,  1'b1);
    expect_idle("sd.idle");
    check("sd.words_saved", words_saved, 16'h0005);

    // Reset between the instruction and its source extension
    send(4'h5, 1'b0, 16'h1234, 4'h5, 1'b0, 16'h0000);
    expect_word("ab.instr", 16'h5035, KIND_INSTR, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("ab.out_valid",   {15'd0, out_valid}, 16'h0000);
    check("ab.in_ready",    {15'd0, in_ready}, 16'h0001);
    check("ab.words_saved", words_saved, 16'h0000);
    check("ab.out_data",    out_data, 16'h0000);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("ab.no_more", {15'd0, out_valid}, 16'h0000);

    // Constant generators disabled: #1 needs an extension word
    opcode = 4'h4; bw = 1'b0; imm = 16'h0001; dstA = 4'h5; Ad = 1'b0; dst_off = 16'h0000;
    n_in_valid = 1'b1;
    @(negedge clk);
    n_in_valid = 1'b0;
    check("nocg.valid",  {15'd0, n_out_valid}, 16'h0001);
    check("nocg.instr",  n_out_data, 16'h4035);
    check("nocg.kind0",  {14'd0, n_out_kind}, {14'd0, KIND_INSTR});
    check("nocg.last0",  {15'd0, n_out_last}, 16'h0000);
    check("nocg.cg_hit", {15'd0, n_cg_hit}, 16'h0000);
    n_out_ready = 1'b1;
    @(negedge clk);
    check("nocg.src",   n_out_data, 16'h0001);
    check("nocg.kind1", {14'd0, n_out_kind}, {14'd0, KIND_SRCX});
    check("nocg.last1", {15'd0, n_out_last}, 16'h0001);
    @(negedge clk);
    n_out_ready = 1'b0;
    check("nocg.done",        {15'd0, n_out_valid}, 16'h0000);
    check("nocg.in_ready",    {15'd0, n_in_ready}, 16'h0001);
    check("nocg.words_saved", n_words_saved, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
